// File: rtl/sw_link_pkg.sv
// Shared definitions for the single-wire link transceiver: FSM encoding,
// frame constants and a counter-width helper.
package sw_link_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_TX_START = 4'd1,
    ST_TX_DATA  = 4'd2,
    ST_TX_STOP  = 4'd3,
    ST_TURN     = 4'd4,
    ST_RX_WAIT  = 4'd5,
    ST_RX_START = 4'd6,
    ST_RX_DATA  = 4'd7,
    ST_RX_STOP  = 4'd8
  } state_e;

  localparam int   FRAME_DATA_BITS = 8;
  // Released line is pulled high, so every idle/reset level is 1.
  localparam logic IDLE_LEVEL      = 1'b1;

  // Bits needed to hold a counter value of max_val without wrapping.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sw_link_sync.sv
// Two-flop synchronizer for the pad input plus falling-edge detection.
// All flops reset to the idle (pulled-up) level so reset never looks like an edge.
module sw_link_sync
  import sw_link_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic sync_o,
  output logic fell_o
);

  logic meta_q, sync_q, prev_q;

  // Synchronizer chain and one-cycle history for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= IDLE_LEVEL;
      sync_q <= IDLE_LEVEL;
      prev_q <= IDLE_LEVEL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fell_o = prev_q & ~sync_q;

endmodule

// File: rtl/sw_link_xcvr.sv
// Half-duplex single-wire transceiver: sends a framed byte, turns the line
// around and captures the reply; also accepts unsolicited frames in IDLE.
// Build option SW_LINK_PARITY_EN adds an even-parity bit after the data bits.
// Handshake: tx byte transfers on a cycle where tx_valid & tx_ready are both
// high; rx_valid/rx_err/rx_timeout are single-cycle pulses with no back-pressure.
module sw_link_xcvr
  import sw_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TURN_CYCLES  = 2,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       pad_i,
  output logic       pad_t,
  input  logic       pad_o,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_err,
  output logic       rx_timeout,
  output logic       busy,
  output state_e     dbg_state
);

`ifdef SW_LINK_PARITY_EN
  localparam int DATA_BITS = FRAME_DATA_BITS + 1;
`else
  localparam int DATA_BITS = FRAME_DATA_BITS;
`endif

  localparam int TO_MAX = (TIMEOUT_BITS * CLKS_PER_BIT > TURN_CYCLES)
                          ? TIMEOUT_BITS * CLKS_PER_BIT : TURN_CYCLES;
  localparam int CW = cnt_width(CLKS_PER_BIT - 1);
  localparam int TW = cnt_width(TO_MAX - 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  localparam logic [3:0]    DB_LAST   = 4'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [TW-1:0]        to_cnt_q, to_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 valid_q, valid_d, err_q, err_d, timeout_q, timeout_d;
  logic                 pad_t_q, pad_t_d, pad_i_q, pad_i_d;
  logic                 from_wait_q, from_wait_d;
  logic                 ready_en_q;
  logic                 line_sync, line_fell, bit_end, parity_ok;
  logic [DATA_BITS-1:0] tx_payload;

  sw_link_sync u_sync (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .d_i    (pad_o),
    .sync_o (line_sync),
    .fell_o (line_fell)
  );

`ifdef SW_LINK_PARITY_EN
  assign tx_payload = {^tx_data, tx_data};
  assign parity_ok  = ~(^rx_shift_q);
`else
  assign tx_payload = tx_data;
  assign parity_ok  = 1'b1;
`endif

  assign bit_end = (clk_cnt_q == BIT_LAST);

  // State and datapath registers; pad controls are registered so a reset
  // releases the pin immediately through the asynchronous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      to_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
      pad_t_q     <= 1'b1;
      pad_i_q     <= IDLE_LEVEL;
      from_wait_q <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      to_cnt_q    <= to_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
      pad_t_q     <= pad_t_d;
      pad_i_q     <= pad_i_d;
      from_wait_q <= from_wait_d;
      ready_en_q  <= 1'b1;
    end
  end

  // Next-state, counters and pulse generation.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    to_cnt_d    = to_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    from_wait_d = from_wait_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    timeout_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A falling edge beats a simultaneous TX request.
        if (line_fell) begin
          state_d     = ST_RX_START;
          clk_cnt_d   = '0;
          from_wait_d = 1'b0;
        end else if (tx_valid && ready_en_q) begin
          state_d    = ST_TX_START;
          tx_shift_d = tx_payload;
          clk_cnt_d  = '0;
        end
      end
      ST_TX_START: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (bit_end) begin
          state_d   = ST_TX_DATA;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      ST_TX_DATA: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (bit_end) begin
          clk_cnt_d  = '0;
          tx_shift_d = tx_shift_q >> 1;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == DB_LAST) state_d = ST_TX_STOP;
        end
      end
      ST_TX_STOP: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (bit_end) begin
          state_d   = ST_TURN;
          clk_cnt_d = '0;
          to_cnt_d  = '0;
        end
      end
      ST_TURN: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (to_cnt_q == TURN_LAST) begin
          state_d  = ST_RX_WAIT;
          to_cnt_d = '0;
        end
      end
      ST_RX_WAIT: begin
        if (line_fell) begin
          state_d     = ST_RX_START;
          clk_cnt_d   = '0;
          from_wait_d = 1'b1;
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_RX_START: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          // A high mid-start sample is a glitch; the timeout count is kept.
          if (line_sync) state_d = from_wait_q ? ST_RX_WAIT : ST_IDLE;
          else           state_d = ST_RX_DATA;
        end
      end
      ST_RX_DATA: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (bit_end) begin
          clk_cnt_d  = '0;
          rx_shift_d = {line_sync, rx_shift_q[DATA_BITS-1:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == DB_LAST) state_d = ST_RX_STOP;
        end
      end
      ST_RX_STOP: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (bit_end) begin
          state_d   = ST_IDLE;
          clk_cnt_d = '0;
          if (line_sync && parity_ok) begin
            valid_d   = 1'b1;
            rx_data_d = rx_shift_q[7:0];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad drive follows the state being entered, giving one-cycle TX latency.
  always_comb begin
    pad_t_d = 1'b1;
    pad_i_d = IDLE_LEVEL;
    case (state_d)
      ST_TX_START: begin pad_t_d = 1'b0; pad_i_d = 1'b0;          end
      ST_TX_DATA:  begin pad_t_d = 1'b0; pad_i_d = tx_shift_d[0]; end
      ST_TX_STOP:  begin pad_t_d = 1'b0; pad_i_d = 1'b1;          end
      default:     begin pad_t_d = 1'b1; pad_i_d = IDLE_LEVEL;    end
    endcase
  end

  assign tx_ready   = ready_en_q && (state_q == ST_IDLE) && !line_fell;
  assign pad_i      = pad_i_q;
  assign pad_t      = pad_t_q;
  assign rx_valid   = valid_q;
  assign rx_data    = rx_data_q;
  assign rx_err     = err_q;
  assign rx_timeout = timeout_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule
